// File: rtl/obstacle_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranging front end.
package ranger_pkg;

    // Every counter in the ranger is this wide; all timing parameters must fit.
    localparam int RNG_W = 23;

    // Defaults for a 100 MHz clock.
    localparam int DEF_PERIOD_CYCLES  = 6_000_000;  // 60 ms ranging period
    localparam int DEF_TRIG_CYCLES    = 1_000;      // 10 us trigger pulse
    localparam int DEF_TIMEOUT_CYCLES = 3_000_000;  // 30 ms echo window
    localparam int DEF_THRESH_CYCLES  = 87_000;     // ~15 cm near threshold
    localparam int DEF_N_CONFIRM      = 3;          // readings to flip obs_det

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [RNG_W-1:0] CNT_ONE = RNG_W'(1);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [RNG_W-1:0] sat_inc(input logic [RNG_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/obstacle_ranger_if.sv
// Sensor pins plus measurement results of the obstacle ranger.
//
// Handshake: meas_valid is a valid-only strobe with no ready. It is high for
// exactly one clock; echo_cycles, timeout and obs_det change on the edge that
// raises it and stay stable until the next strobe. Consumers must capture on
// that cycle; there is no back-pressure.
interface obstacle_ranger_if;
    import ranger_pkg::*;

    logic             echo;         // raw sensor echo, asynchronous to clk
    logic             trig;         // sensor trigger
    logic             obs_det;      // 0 = obstacle confirmed, 1 = clear
    logic [RNG_W-1:0] echo_cycles;  // last echo width, 0 after a timeout
    logic             meas_valid;   // one-cycle update strobe
    logic             timeout;      // last measurement timed out
    state_t           state;        // FSM state, debug visibility

    // Ranger side: drives trigger and results, receives the echo.
    modport master (
        input  echo,
        output trig, obs_det, echo_cycles, meas_valid, timeout, state
    );

    // Sensor / consumer side.
    modport slave (
        output echo,
        input  trig, obs_det, echo_cycles, meas_valid, timeout, state
    );

endinterface

// File: rtl/obstacle_ranger_sync_2ff.sv
// Two-flop single-bit synchronizer, clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous input and let the first stage settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/obstacle_ranger.sv
// Ultrasonic ranging front end: periodic trigger, echo width timing,
// near/far classification with N-reading confirmation into obs_det.
module obstacle_ranger
    import ranger_pkg::*;
#(
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int THRESH_CYCLES  = DEF_THRESH_CYCLES,
    parameter int N_CONFIRM      = DEF_N_CONFIRM
) (
    input  logic              clk,
    input  logic              rst,
    obstacle_ranger_if.master rng
);

    localparam logic [RNG_W-1:0] PERIOD_LAST  = RNG_W'(PERIOD_CYCLES - 1);
    localparam logic [RNG_W-1:0] TRIG_LAST    = RNG_W'(TRIG_CYCLES - 1);
    localparam logic [RNG_W-1:0] TIMEOUT_LAST = RNG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RNG_W-1:0] THRESH       = RNG_W'(THRESH_CYCLES);
    localparam logic [3:0]       N_CONF       = 4'(N_CONFIRM);

    // The whole trigger + echo window must finish before the period wraps,
    // so IDLE is the only state that ever sees the wrap.
    generate
        if (TRIG_CYCLES + TIMEOUT_CYCLES + 4 >= PERIOD_CYCLES) begin : g_bad_period
            $error("obstacle_ranger: TRIG_CYCLES + TIMEOUT_CYCLES + 4 must be < PERIOD_CYCLES");
        end
        if (PERIOD_CYCLES >= (1 << RNG_W) || TRIG_CYCLES < 1 || TIMEOUT_CYCLES < 1
            || THRESH_CYCLES >= (1 << RNG_W)) begin : g_bad_range
            $error("obstacle_ranger: timing parameters must be positive and below 2^23");
        end
        if (N_CONFIRM < 1 || N_CONFIRM > 15) begin : g_bad_confirm
            $error("obstacle_ranger: N_CONFIRM must be in 1..15");
        end
    endgenerate

    logic echo_s;

    sync_2ff u_echo_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rng.echo),
        .q_o (echo_s)
    );

    state_t           state_q, state_d;
    logic [RNG_W-1:0] pcnt_q;
    logic [RNG_W-1:0] tcnt_q, tcnt_d;      // trigger length, then timeout timer
    logic [RNG_W-1:0] wcnt_q, wcnt_d;      // echo width
    logic             fin_to;              // entering DONE because of timeout
    logic             trig_q;
    logic             obs_q, obs_d;
    logic [RNG_W-1:0] echo_cyc_q, echo_cyc_d;
    logic             mvalid_q, mvalid_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       run_q, run_d, run_inc;
    logic             near;

    // Free-running period counter; its wrap schedules every trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else if (pcnt_q == PERIOD_LAST) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + CNT_ONE;
        end
    end

    // Next-state logic: trigger, wait for echo, time it, or give up.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        wcnt_d  = wcnt_q;
        fin_to  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pcnt_q == PERIOD_LAST) begin
                    state_d = TRIG;
                    tcnt_d  = '0;
                end
            end
            TRIG: begin
                if (tcnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + CNT_ONE;
                end
            end
            WAIT_RISE: begin
                tcnt_d = tcnt_q + CNT_ONE;
                if (tcnt_q == TIMEOUT_LAST) begin
                    state_d = DONE;
                    fin_to  = 1'b1;
                end else if (echo_s) begin
                    // A stale echo that is already high counts as the rise.
                    state_d = MEASURE;
                    wcnt_d  = CNT_ONE;
                end
            end
            MEASURE: begin
                tcnt_d = tcnt_q + CNT_ONE;
                if (tcnt_q == TIMEOUT_LAST) begin
                    state_d = DONE;
                    fin_to  = 1'b1;
                end else if (echo_s) begin
                    wcnt_d = sat_inc(wcnt_q);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result and confirm logic, evaluated on the edge that enters DONE so the
    // outputs change together with the meas_valid strobe.
    always_comb begin
        mvalid_d   = 1'b0;
        echo_cyc_d = echo_cyc_q;
        timeout_d  = timeout_q;
        obs_d      = obs_q;
        run_d      = run_q;
        near       = 1'b0;
        run_inc    = run_q + 4'd1;
        if (state_d == DONE) begin
            mvalid_d   = 1'b1;
            echo_cyc_d = fin_to ? '0 : wcnt_q;
            timeout_d  = fin_to;
            near       = !fin_to && (wcnt_q < THRESH);
            // obs_det is active low, so a near reading disagrees when obs_q is 1.
            if (near == obs_q) begin
                if (run_inc == N_CONF) begin
                    obs_d = ~obs_q;
                    run_d = '0;
                end else begin
                    run_d = run_inc;
                end
            end else begin
                run_d = '0;
            end
        end
    end

    // FSM and measurement counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Registered outputs; reset clears them asynchronously, dropping trig at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q     <= 1'b0;
            obs_q      <= 1'b1;
            echo_cyc_q <= '0;
            mvalid_q   <= 1'b0;
            timeout_q  <= 1'b0;
            run_q      <= '0;
        end else begin
            trig_q     <= (state_d == TRIG);
            obs_q      <= obs_d;
            echo_cyc_q <= echo_cyc_d;
            mvalid_q   <= mvalid_d;
            timeout_q  <= timeout_d;
            run_q      <= run_d;
        end
    end

    assign rng.trig        = trig_q;
    assign rng.obs_det     = obs_q;
    assign rng.echo_cycles = echo_cyc_q;
    assign rng.meas_valid  = mvalid_q;
    assign rng.timeout     = timeout_q;
    assign rng.state       = state_q;

endmodule

// File: tb/tb_obstacle_ranger.sv
// Directed bench for obstacle_ranger with reduced timing parameters.
`timescale 1ns/1ps
module tb_obstacle_ranger;
    import ranger_pkg::*;

    localparam int P  = 2000;
    localparam int T  = 10;
    localparam int TO = 1500;
    localparam int TH = 500;
    localparam int NC = 2;
    localparam int W  = RNG_W + 2;   // {timeout, obs_det, echo_cycles}

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    logic [W-1:0] mon_e;
    int           mon_t;

    obstacle_ranger_if rif ();

    obstacle_ranger #(
        .PERIOD_CYCLES  (P),
        .TRIG_CYCLES    (T),
        .TIMEOUT_CYCLES (TO),
        .THRESH_CYCLES  (TH),
        .N_CONFIRM      (NC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rng (rif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string name, input int got, input int exp, input int tol);
        n_checks++;
        if (got < exp - tol || got > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d (cyc %0d)", name, got, exp, tol, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_meas(input int t, input logic to, input logic obs, input int w);
        exp_q.push_back({to, obs, RNG_W'(w)});
        exp_t_q.push_back(t);
    endtask

    // Trigger rises on edge b and stays high T clocks.
    task automatic check_trig(input int b);
        wait_cyc(b - 1);
        chk("trig_before_rise", rif.trig, 0);
        wait_cyc(b);
        chk("trig_rise", rif.trig, 1);
        wait_cyc(b + T - 1);
        chk("trig_last_high", rif.trig, 1);
        wait_cyc(b + T);
        chk("trig_fall", rif.trig, 0);
    endtask

    // Echo of w clocks starting 50 clocks after trigger fall of period n.
    task automatic echo_period(input int n, input int w, input logic obs_exp);
        int e;
        e = n * P + T;
        expect_meas(e + 50 + w + 3, 1'b0, obs_exp, w);
        wait_cyc(e + 50);
        rif.echo = 1'b1;
        wait_cyc(e + 50 + w);
        rif.echo = 1'b0;
        wait_cyc(e + 50 + w + 4);
    endtask

    // No echo at all in period n.
    task automatic timeout_period(input int n, input logic obs_exp);
        int e;
        e = n * P + T;
        expect_meas(e + TO, 1'b1, obs_exp, 0);
        wait_cyc(e + TO + 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && rif.meas_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_meas_valid: got pulse at cyc %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = exp_t_q.pop_front();
                chk("meas_valid_time", cyc, mon_t);
                chk("timeout", rif.timeout, mon_e[W-1]);
                chk("obs_det", rif.obs_det, mon_e[W-2]);
                chk_tol("echo_cycles", rif.echo_cycles, mon_e[RNG_W-1:0], mon_e[W-1] ? 0 : 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int e;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rif.echo = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_trig", rif.trig, 0);
        chk("rst_obs_det", rif.obs_det, 1);
        chk("rst_echo_cycles", rif.echo_cycles, 0);
        chk("rst_meas_valid", rif.meas_valid, 0);
        chk("rst_timeout", rif.timeout, 0);
        chk("rst_state", int'(rif.state), int'(IDLE));
        rst = 1'b0;

        wait_cyc(P - 2);
        chk("pre_trig_obs_det", rif.obs_det, 1);
        chk("pre_trig_echo_cycles", rif.echo_cycles, 0);
        chk("pre_trig_timeout", rif.timeout, 0);
        check_trig(P);

        // Near readings: first does not flip, second confirms obstacle.
        echo_period(1, 300, 1'b1);
        check_trig(2 * P);
        echo_period(2, 300, 1'b0);
        echo_period(3, 300, 1'b0);

        // Two timeouts while obstacle is flagged bring obs_det back to clear.
        timeout_period(4, 1'b0);
        wait_cyc(5 * P + 5);
        chk("timeout_held", rif.timeout, 1);
        timeout_period(5, 1'b1);

        // Near then far: the far reading breaks the run.
        echo_period(6, 300, 1'b1);
        echo_period(7, 800, 1'b1);
        echo_period(8, 300, 1'b1);
        echo_period(9, 300, 1'b0);

        // Stuck echo: rises after trigger, never falls; times out.
        e = 10 * P + T;
        expect_meas(e + TO, 1'b1, 1'b0, 0);
        wait_cyc(e + 50);
        rif.echo = 1'b1;
        wait_cyc(11 * P - 1);
        chk("stuck_trig_before", rif.trig, 0);
        wait_cyc(11 * P);
        chk("stuck_trig_on_schedule", rif.trig, 1);
        wait_cyc(11 * P + 5);
        rif.echo = 1'b0;
        wait_cyc(11 * P + T);
        chk("stuck_trig_fall", rif.trig, 0);
        echo_period(11, 300, 1'b0);

        // Reset 100 clocks into an echo while obstacle is flagged.
        e = 12 * P + T;
        wait_cyc(e + 50);
        rif.echo = 1'b1;
        wait_cyc(e + 150);
        chk("pre_reset_obs_det", rif.obs_det, 0);
        rst = 1'b1;
        #1;
        chk("midrst_trig", rif.trig, 0);
        chk("midrst_obs_det", rif.obs_det, 1);
        chk("midrst_echo_cycles", rif.echo_cycles, 0);
        chk("midrst_state", int'(rif.state), int'(IDLE));
        rif.echo = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset during the trigger pulse drops trig without a clock.
        wait_cyc(P + 5);
        chk("trig_before_async_rst", rif.trig, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_trig", rif.trig, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh start: full period, then one near reading.
        check_trig(P);
        echo_period(1, 300, 1'b1);
        wait_cyc(P + T + 500);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
